// File: rtl/window_slide_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : window_slide_pkg
//  Brief    : Shared types and sizing helpers for the multi-channel sliding
//             window generator (window_slide_mc).
//             Optional feature macro: WINDOW_SLIDE_ZPAD_EN (virtual zero border).
//  Revision : 1.0  initial release
// ============================================================================
package window_slide_pkg;

    // Walk controller states
    typedef enum logic [1:0] {
        WS_IDLE  = 2'd0,
        WS_FETCH = 2'd1,
        WS_HOLD  = 2'd2,
        WS_DONE  = 2'd3
    } ws_state_e;

`ifdef WINDOW_SLIDE_ZPAD_EN
    localparam bit WS_ZPAD_EN = 1'b1;
`else
    localparam bit WS_ZPAD_EN = 1'b0;
`endif

    // Number of window positions along one image axis
    function automatic int ws_out_dim(input int len, input int k, input int s, input int p);
        return (len + 2 * p - k) / s + 1;
    endfunction

    // Width of the virtual zero border for a K-wide kernel
    function automatic int ws_pad(input int k);
        return WS_ZPAD_EN ? (k - 1) / 2 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_slide_mc_image_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ws_image_ram
//  Brief    : Single-image pixel store: one write port, one synchronous read
//             port with one cycle of read latency. Contents are not reset.
//  Revision : 1.0  initial release
// ============================================================================
module ws_image_ram #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 100,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_slide_mc.sv
`default_nettype none
// ============================================================================
//  Module   : window_slide_mc
//  Brief    : Buffers one multi-channel image, then on start walks every KxK
//             window at STRIDE in raster order and presents each window on a
//             valid/ready stream with its output-grid position.
//             Optional feature macro: WINDOW_SLIDE_ZPAD_EN adds a (K-1)/2
//             virtual zero border around the image.
//  Revision : 1.0  initial release
// ============================================================================
module window_slide_mc
    import window_slide_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CH        = 2,
    parameter int IMAGE_ROW_LEN = 10,
    parameter int IMAGE_COL_LEN = 10,
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int ADDR_WIDTH    = $clog2(IMAGE_ROW_LEN * IMAGE_COL_LEN + 1),
    localparam int PAD          = ws_pad(KERNEL_SIZE),
    localparam int OUT_ROWS     = ws_out_dim(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE, PAD),
    localparam int OUT_COLS     = ws_out_dim(IMAGE_COL_LEN, KERNEL_SIZE, STRIDE, PAD),
    localparam int ROW_W        = $clog2(OUT_ROWS + 1),
    localparam int COL_W        = $clog2(OUT_COLS + 1)
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   ram_in_wen,
    input  logic [ADDR_WIDTH-1:0]                                  ram_in_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                           ram_in_data,
    input  logic                                                   start,
    output logic                                                   busy,
    output logic [KERNEL_SIZE*KERNEL_SIZE*NUM_CH*DATA_WIDTH-1:0]   y_out,
    output logic                                                   y_valid,
    input  logic                                                   y_ready,
    output logic [ROW_W-1:0]                                       win_row,
    output logic [COL_W-1:0]                                       win_col,
    output logic                                                   done
);

    localparam int PIX_W = NUM_CH * DATA_WIDTH;
    localparam int NK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DEPTH = IMAGE_ROW_LEN * IMAGE_COL_LEN;
    // Element counter runs 0..NK+1: NK read-issue cycles plus two drain cycles
    localparam int EW    = $clog2(NK + 2);
    localparam int KW    = $clog2(KERNEL_SIZE + 1);

    localparam logic [EW-1:0]         ELEM_ISSUE_END = EW'(NK);
    localparam logic [EW-1:0]         ELEM_LAST      = EW'(NK + 1);
    localparam logic [KW-1:0]         K_LAST         = KW'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST       = ROW_W'(OUT_ROWS - 1);
    localparam logic [COL_W-1:0]      COL_LAST       = COL_W'(OUT_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A        = ADDR_WIDTH'(DEPTH);

    ws_state_e             r_state;
    ws_state_e             w_state_nxt;
    logic [EW-1:0]         r_elem;
    logic [KW-1:0]         r_kr;
    logic [KW-1:0]         r_kc;
    logic                  w_issue;
    logic                  w_oob;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_last;
    int                    w_img_r;
    int                    w_img_c;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [PIX_W-1:0]      w_rdata;
    logic                  r_cap_vld;
    logic                  r_cap_zero;
    logic [EW-1:0]         r_cap_e;

    assign w_last  = (win_row == ROW_LAST) && (win_col == COL_LAST);
    assign w_issue = (r_state == WS_FETCH) && (r_elem < ELEM_ISSUE_END);
    assign w_rd_en = w_issue && !w_oob;
    // Image loading is locked out for the whole walk
    assign w_wr_en = ram_in_wen && !busy && (ram_in_addr < DEPTH_A);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        y_valid     = 1'b0;
        done        = 1'b0;
        case (r_state)
            WS_IDLE: begin
                if (start) begin
                    w_state_nxt = WS_FETCH;
                end
            end
            WS_FETCH: begin
                busy = 1'b1;
                if (r_elem == ELEM_LAST) begin
                    w_state_nxt = WS_HOLD;
                end
            end
            WS_HOLD: begin
                busy    = 1'b1;
                y_valid = 1'b1;
                if (y_ready) begin
                    w_state_nxt = w_last ? WS_DONE : WS_FETCH;
                end
            end
            WS_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = WS_IDLE;
            end
            default: begin
                w_state_nxt = WS_IDLE;
            end
        endcase
    end

    // Element and output-grid counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_elem  <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            win_row <= '0;
            win_col <= '0;
        end else begin
            case (r_state)
                WS_IDLE: begin
                    if (start) begin
                        r_elem  <= '0;
                        r_kr    <= '0;
                        r_kc    <= '0;
                        win_row <= '0;
                        win_col <= '0;
                    end
                end
                WS_FETCH: begin
                    if (r_elem != ELEM_LAST) begin
                        r_elem <= r_elem + 1'b1;
                    end
                    if (w_issue) begin
                        if (r_kc == K_LAST) begin
                            r_kc <= '0;
                            r_kr <= r_kr + 1'b1;
                        end else begin
                            r_kc <= r_kc + 1'b1;
                        end
                    end
                end
                WS_HOLD: begin
                    if (y_ready) begin
                        r_elem <= '0;
                        r_kr   <= '0;
                        r_kc   <= '0;
                        // The final position is kept so it stays visible through DONE
                        if (!w_last) begin
                            if (win_col == COL_LAST) begin
                                win_col <= '0;
                                win_row <= win_row + 1'b1;
                            end else begin
                                win_col <= win_col + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Image coordinate of the element being fetched; off-image coordinates exist only with the zero border
    always_comb begin
        w_img_r   = int'(win_row) * STRIDE + int'(r_kr) - PAD;
        w_img_c   = int'(win_col) * STRIDE + int'(r_kc) - PAD;
        w_oob     = (w_img_r < 0) || (w_img_r >= IMAGE_ROW_LEN) ||
                    (w_img_c < 0) || (w_img_c >= IMAGE_COL_LEN);
        w_rd_addr = w_oob ? '0 : ADDR_WIDTH'(w_img_r * IMAGE_COL_LEN + w_img_c);
    end

    // Track each issued read through the RAM latency and drop its data into the window slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_vld  <= 1'b0;
            r_cap_zero <= 1'b0;
            r_cap_e    <= '0;
            y_out      <= '0;
        end else begin
            r_cap_vld  <= w_issue;
            r_cap_zero <= w_oob;
            r_cap_e    <= r_elem;
            if (r_cap_vld) begin
                y_out[int'(r_cap_e) * PIX_W +: PIX_W] <= r_cap_zero ? '0 : w_rdata;
            end
        end
    end

    ws_image_ram #(
        .DATA_W     (PIX_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_image_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (ram_in_addr),
        .wr_data (ram_in_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rdata)
    );

endmodule
`default_nettype wire
